ram_stream_reader: RTL and testbench

- Read-side sequencer placed directly downstream of the team's simple dual-port RAM.
- On a start command it issues sequential reads (rd_en/rd_addr) and captures the returned words into a small prefetch FIFO.
- The FIFO drains onto an AXI4-Stream-style master interface with full tready backpressure and tlast.
- Lets a frame buffer written by one agent be streamed out by a downstream consumer.

---
 rtl/ram_stream_reader_pkg.sv | 27 ++
 rtl/ram_stream_reader_if.sv | 12 +
 rtl/sync_fifo_fwft.sv | 57 +++++
 rtl/ram_stream_reader.sv | 219 +++++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and parameter checks for ram_stream_reader.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ENTRY_DATA_WIDTH = 8;

    typedef struct packed {
        logic                        tlast;
        logic [ENTRY_DATA_WIDTH-1:0] data;
    } fifo_entry_t;

    function automatic bit rd_latency_legal(input int latency);
        return (latency == 1) || (latency == 2);
    endfunction

    // Depth must be a power of two with room for every in-flight read plus a beat.
    function automatic bit fifo_depth_legal(input int depth, input int latency);
        return (depth >= latency + 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// AXI4-Stream style master/slave channel used by ram_stream_reader.
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head entry is visible whenever empty_o is low.
module sync_fifo_fwft #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o     = (count_r == CNT_W'(DEPTH));
    assign empty_o    = (count_r == {CNT_W{1'b0}});
    assign count_o    = count_r;
    assign pop_data_o = mem_r[rd_ptr_r];
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign push_ok_s  = push_i & (~full_o | pop_i);
    assign pop_ok_s   = pop_i & ~empty_o;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data_i;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/ram_stream_reader.sv
// Streams a block of RAM words out over an AXI4-Stream style master with credit-limited prefetch.
// Optional checker enabled by defining RAM_STREAM_READER_ERR_CHECK_EN.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = ENTRY_DATA_WIDTH,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rd_data_valid_i,
    ram_stream_reader_if.master   m_axis
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1'b1);

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $error("ram_stream_reader: RD_LATENCY must be 1 or 2");
    end
    if (!fifo_depth_legal(FIFO_DEPTH, RD_LATENCY)) begin : g_bad_depth
        $error("ram_stream_reader: FIFO_DEPTH must be a power of two >= RD_LATENCY+2");
    end
    if (DATA_WIDTH != ENTRY_DATA_WIDTH) begin : g_bad_width
        $error("ram_stream_reader: DATA_WIDTH must match the FIFO entry data width");
    end

    state_t                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [ADDR_WIDTH:0]    remaining_r;
    logic                   real_prev_r;
    logic [RD_LATENCY-1:0]  tag_r;
    logic [RD_LATENCY-1:0]  last_tag_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   issue_s;
    logic                   dummy_s;
    logic                   credit_s;
    logic [SUM_W-1:0]       outstanding_s;
    logic [CNT_W-1:0]       fifo_count_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   push_s;
    logic                   pop_s;
    fifo_entry_t            push_entry_s;
    fifo_entry_t            pop_entry_s;

    // Reads issued but not yet captured, one per set tag bit.
    always_comb begin
        outstanding_s = {SUM_W{1'b0}};
        for (int i = 0; i < RD_LATENCY; i++) begin
            outstanding_s = outstanding_s + SUM_W'(tag_r[i]);
        end
    end

    assign credit_s = (SUM_W'(fifo_count_s) + outstanding_s) < SUM_W'(FIFO_DEPTH);

    // Next-state and read-issue decode.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    if (length_i != {(ADDR_WIDTH + 1){1'b0}}) begin
                        state_s = READ;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (credit_s) begin
                    issue_s = 1'b1;
                    if (remaining_r == LEN_ONE) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = READ;
                end
            end
            DRAIN: begin
                if (pop_s && pop_entry_s.tlast) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // A registered RAM only advances its output stage while rd_en is high, so a
    // real read must always be followed by one more enabled cycle.
    always_comb begin
        if (RD_LATENCY == 2) begin
            dummy_s = real_prev_r & ~issue_s;
        end else begin
            dummy_s = 1'b0;
        end
    end

    assign rd_en_o   = issue_s | dummy_s;
    assign rd_addr_o = dummy_s ? (addr_r - ADDR_ONE) : addr_r;

    // Control state, address and word counters, status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            remaining_r <= {(ADDR_WIDTH + 1){1'b0}};
            real_prev_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            real_prev_r <= issue_s;
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == DONE);
            if (state_r == IDLE && start_i) begin
                addr_r      <= start_addr_i;
                remaining_r <= length_i;
            end else if (issue_s) begin
                addr_r      <= addr_r + ADDR_ONE;
                remaining_r <= remaining_r - LEN_ONE;
            end
        end
    end

    // Tag pipeline aligned with the RAM latency; the last flag travels with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_r      <= {RD_LATENCY{1'b0}};
            last_tag_r <= {RD_LATENCY{1'b0}};
        end else begin
            tag_r[0]      <= issue_s;
            last_tag_r[0] <= issue_s & (remaining_r == LEN_ONE);
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_r[i]      <= tag_r[i-1];
                last_tag_r[i] <= last_tag_r[i-1];
            end
        end
    end

    assign push_s       = tag_r[RD_LATENCY-1];
    assign push_entry_s = {last_tag_r[RD_LATENCY-1], rd_data_i};
    assign pop_s        = ~fifo_empty_s & m_axis.tready;

    sync_fifo_fwft #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .pop_data_o  (pop_entry_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    assign m_axis.tdata  = pop_entry_s.data;
    assign m_axis.tvalid = ~fifo_empty_s;
    assign m_axis.tlast  = pop_entry_s.tlast;
    assign busy_o        = busy_r;
    assign done_o        = done_r;

`ifdef RAM_STREAM_READER_ERR_CHECK_EN
    logic [RD_LATENCY-1:0] dummy_tag_r;
    logic                  err_r;
    logic                  valid_exp_s;

    assign valid_exp_s = tag_r[RD_LATENCY-1] | dummy_tag_r[RD_LATENCY-1];

    // Sticky flag for unexpected RAM valid timing or FIFO overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dummy_tag_r <= {RD_LATENCY{1'b0}};
            err_r       <= 1'b0;
        end else begin
            dummy_tag_r[0] <= dummy_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                dummy_tag_r[i] <= dummy_tag_r[i-1];
            end
            if ((rd_data_valid_i != valid_exp_s) || (push_s && fifo_full_s && !pop_s)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign err_o = err_r;
`else
    logic unused_err_s;
    assign unused_err_s = rd_data_valid_i ^ fifo_full_s;
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a registered-output RAM model (RD_LATENCY=2).
module tb_ram_stream_reader;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy, done, err, rd_en, rd_valid, tready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] st1, st2;
    logic          v1, v2;

    int n_cmp = 0;
    int n_err = 0;

    ram_stream_reader_if #(.DATA_WIDTH(DW)) axis_if ();
    assign axis_if.tready = tready;

    ram_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (2),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .start_addr_i    (start_addr),
        .length_i        (length),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .rd_en_o         (rd_en),
        .rd_addr_o       (rd_addr),
        .rd_data_i       (rd_data),
        .rd_data_valid_i (rd_valid),
        .m_axis          (axis_if)
    );

    always #5 clk = ~clk;

    // RAM with output register: both stages advance only while rd_en is high.
    always @(posedge clk) begin
        if (rd_en) begin
            st1 <= mem[rd_addr];
            st2 <= st1;
        end
        v1 <= rd_en;
        v2 <= v1;
    end
    assign rd_data  = st2;
    assign rd_valid = v2;

    typedef struct {
        logic [7:0] addr;
        logic [8:0] len;
        int         ready_pct;
        bit         poke;
        int         exp_beats;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
        int         exp_dummies;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int beats = 0, reals = 0, dummies = 0, done_cnt = 0;
        int first_hs = -1, last_hs = -1, done_cyc = -1;
        logic [7:0] next_addr = v.addr;
        logic [7:0] first_d = 8'h00, last_d = 8'h00, exp_d;
        logic prev_stall = 1'b0, prev_last = 1'b0;
        logic [7:0] prev_data = 8'h00;
        bit finished = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            start      = (cyc == 0) || (v.poke && cyc == 3);
            start_addr = (cyc == 0) ? v.addr : 8'h00;
            length     = (cyc == 0) ? v.len : 9'd2;
            tready     = ($urandom_range(0, 99) < v.ready_pct);
            #1;
            if (prev_stall) begin
                chk("tvalid_hold", int'(axis_if.tvalid), 1);
                chk("tdata_hold", int'(axis_if.tdata), int'(prev_data));
                chk("tlast_hold", int'(axis_if.tlast), int'(prev_last));
            end
            if (rd_en) begin
                if (rd_addr == next_addr && reals < int'(v.len)) begin
                    reals++;
                    next_addr = next_addr + 8'd1;
                end else if (reals > 0 && rd_addr == next_addr - 8'd1) begin
                    dummies++;
                end else begin
                    chk("rd_addr_seq", int'(rd_addr), int'(next_addr));
                end
            end
            if (reals - beats > DEPTH) chk("credit", reals - beats, DEPTH);
            if (cyc == 1) chk("busy_after_start", int'(busy), 1);
            if (axis_if.tvalid && tready) begin
                exp_d = 8'hFF ^ (v.addr + 8'(beats));
                chk("tdata", int'(axis_if.tdata), int'(exp_d));
                chk("tlast", int'(axis_if.tlast), int'(beats == int'(v.len) - 1));
                if (beats == 0) begin
                    first_hs = cyc;
                    first_d  = axis_if.tdata;
                end
                last_hs = cyc;
                last_d  = axis_if.tdata;
                beats++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) chk("busy_after_done", int'(busy), 0);
            if (done_cyc >= 0 && cyc >= done_cyc + 2) finished = 1'b1;
            prev_stall = axis_if.tvalid & ~tready;
            prev_data  = axis_if.tdata;
            prev_last  = axis_if.tlast;
        end
        start  = 1'b0;
        tready = 1'b0;
        chk("xfer_timeout", int'(finished), 1);
        chk("beats", beats, v.exp_beats);
        chk("real_reads", reals, int'(v.len));
        chk("done_count", done_cnt, 1);
        chk("err", int'(err), 0);
        if (v.exp_dummies >= 0) chk("dummy_reads", dummies, v.exp_dummies);
        if (v.len == 9'd0) begin
            chk("done_cycle_len0", done_cyc, 1);
        end else begin
            chk("done_cycle", done_cyc, last_hs + 1);
            chk("first_word", int'(first_d), int'(v.exp_first));
            chk("last_word", int'(last_d), int'(v.exp_last));
            if (v.ready_pct == 100) chk("beat_span", last_hs - first_hs, int'(v.len) - 1);
        end
    endtask

    initial begin
        int done_seen;
        vec_t rv;
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF ^ 8'(i);
        //          addr   len     rdy  poke beats first  last   dummies
        vecs[0] = '{8'h00, 9'd16,  100, 1'b0, 16,  8'hFF, 8'hF0, 1};
        vecs[1] = '{8'hFC, 9'd8,   100, 1'b0, 8,   8'h03, 8'hFC, 1};
        vecs[2] = '{8'h10, 9'd64,  30,  1'b0, 64,  8'hEF, 8'hB0, -1};
        vecs[3] = '{8'h80, 9'd1,   100, 1'b0, 1,   8'h7F, 8'h7F, 1};
        vecs[4] = '{8'h00, 9'd0,   100, 1'b0, 0,   8'h00, 8'h00, 0};
        vecs[5] = '{8'h20, 9'd8,   100, 1'b1, 8,   8'hDF, 8'hD8, 1};
        vecs[6] = '{8'h00, 9'd256, 100, 1'b0, 256, 8'hFF, 8'h00, 1};
        vecs[7] = '{8'hF0, 9'd20,  50,  1'b1, 20,  8'h0F, 8'hFC, -1};

        rst = 1'b1; start = 1'b0; start_addr = 8'h00; length = 9'd0; tready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_tvalid", int'(axis_if.tvalid), 0);
        chk("rst_tlast", int'(axis_if.tlast), 0);
        rst = 1'b0;

        foreach (vecs[i]) run_xfer(vecs[i]);

        // Reset in the middle of a transfer, then a fresh short transfer.
        done_seen = 0;
        @(negedge clk);
        start = 1'b1; start_addr = 8'h40; length = 9'd32; tready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) done_seen++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_tvalid", int'(axis_if.tvalid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rd_en", int'(rd_en), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (done) done_seen++;
            if (axis_if.tvalid) chk("midrst_stale_beat", 1, 0);
        end
        chk("midrst_no_done", done_seen, 0);
        rv = '{8'h50, 9'd4, 100, 1'b0, 4, 8'hAF, 8'hAC, 1};
        run_xfer(rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
